// File: rtl/zxuno_joy_pkg.sv
// Shared joystick-path definitions: pad type codes, pad reader states and the
// bit layout of the decoder's {btn2,fire,up,down,left,right} vector.
package zxuno_joy_pkg;

    typedef enum logic [1:0] {
        PAD_NONE = 2'd0,
        PAD_MD3  = 2'd1,
        PAD_MD6  = 2'd2
    } pad_type_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_S4,
        ST_S5,
        ST_S6,
        ST_S7
    } pad_state_e;

    // Decoder vector bit positions, active-low.
    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_FIRE  = 4;
    localparam int JOY_BTN2  = 5;

    // Raw DB9 pin positions within joy_pins.
    localparam int PIN_4 = 0;
    localparam int PIN_3 = 1;
    localparam int PIN_2 = 2;
    localparam int PIN_1 = 3;
    localparam int PIN_6 = 4;
    localparam int PIN_9 = 5;

    // Extra Megadrive button positions within md_extra_n.
    localparam int MDX_A     = 0;
    localparam int MDX_START = 1;
    localparam int MDX_X     = 2;
    localparam int MDX_Y     = 3;
    localparam int MDX_Z     = 4;
    localparam int MDX_MODE  = 5;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for bringing asynchronous levels into clk.
module sync2 #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/md_pad_reader.sv
// DB9 pad poller: walks SELECT through an 8-step sequence, detects Atari /
// MD 3-button / MD 6-button pads and commits a frame-consistent button set.
module md_pad_reader
    import zxuno_joy_pkg::*;
#(
    parameter int STEP_CYCLES = 280,
    parameter int IDLE_STEPS  = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] joy_pins,
    output logic       joy_select,
    output logic [5:0] db9joy_out,
    output logic [5:0] md_extra_n,
    output logic [1:0] pad_type,
    output logic       poll_done
);

    localparam int SW = $clog2(STEP_CYCLES);
    localparam int IW = $clog2(IDLE_STEPS);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_STEPS - 1);

    logic [5:0]    pins_s;
    logic [SW-1:0] step_cnt;
    logic          tick;
    logic [IW-1:0] idle_cnt;
    pad_state_e    state;

    logic [5:0]    dir_smp;
    logic          a_smp;
    logic          start_smp;
    logic [3:0]    mzyx_smp;
    logic          md_seen;
    logic          six_seen;

    sync2 #(
        .WIDTH       (6),
        .RESET_VALUE (6'h3F)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (joy_pins),
        .q     (pins_s)
    );

    assign tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || tick) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    // Everything advances on tick only, so each step gives the pad
    // STEP_CYCLES-1 clocks to settle after a SELECT edge before sampling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idle_cnt   <= '0;
            joy_select <= 1'b1;
            dir_smp    <= 6'h3F;
            a_smp      <= 1'b1;
            start_smp  <= 1'b1;
            mzyx_smp   <= 4'hF;
            md_seen    <= 1'b0;
            six_seen   <= 1'b0;
            db9joy_out <= 6'h3F;
            md_extra_n <= 6'h3F;
            pad_type   <= PAD_NONE;
            poll_done  <= 1'b0;
        end else begin
            poll_done <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            md_seen  <= 1'b0;
                            six_seen <= 1'b0;
                            state    <= ST_S0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    ST_S0: begin
                        dir_smp[JOY_BTN2]  <= pins_s[PIN_9];
                        dir_smp[JOY_FIRE]  <= pins_s[PIN_6];
                        dir_smp[JOY_UP]    <= pins_s[PIN_1];
                        dir_smp[JOY_DOWN]  <= pins_s[PIN_2];
                        dir_smp[JOY_LEFT]  <= pins_s[PIN_3];
                        dir_smp[JOY_RIGHT] <= pins_s[PIN_4];
                        state      <= ST_S1;
                        joy_select <= 1'b0;
                    end
                    ST_S1: begin
                        a_smp     <= pins_s[PIN_6];
                        start_smp <= pins_s[PIN_9];
                        if (!pins_s[PIN_3] && !pins_s[PIN_4]) begin
                            md_seen <= 1'b1;
                        end
                        state      <= ST_S2;
                        joy_select <= 1'b1;
                    end
                    ST_S2: begin
                        state      <= ST_S3;
                        joy_select <= 1'b0;
                    end
                    ST_S3: begin
                        state      <= ST_S4;
                        joy_select <= 1'b1;
                    end
                    ST_S4: begin
                        state      <= ST_S5;
                        joy_select <= 1'b0;
                    end
                    ST_S5: begin
                        if (md_seen && (pins_s[PIN_1:PIN_4] == 4'b0000)) begin
                            six_seen <= 1'b1;
                        end
                        state      <= ST_S6;
                        joy_select <= 1'b1;
                    end
                    ST_S6: begin
                        mzyx_smp   <= {pins_s[PIN_4], pins_s[PIN_1], pins_s[PIN_2], pins_s[PIN_3]};
                        state      <= ST_S7;
                        joy_select <= 1'b0;
                    end
                    ST_S7: begin
                        // Single commit point keeps all three outputs from the same poll.
                        db9joy_out <= dir_smp;
                        poll_done  <= 1'b1;
                        if (!md_seen) begin
                            pad_type   <= PAD_NONE;
                            md_extra_n <= 6'h3F;
                        end else if (!six_seen) begin
                            pad_type   <= PAD_MD3;
                            md_extra_n <= {4'hF, start_smp, a_smp};
                        end else begin
                            pad_type   <= PAD_MD6;
                            md_extra_n <= {mzyx_smp, start_smp, a_smp};
                        end
                        state      <= ST_IDLE;
                        joy_select <= 1'b1;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        joy_select <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_pad_reader.sv
// Self-checking bench for md_pad_reader: a behavioural DB9 pad (Atari, MD3,
// MD6 or unplugged) drives the pins from SELECT; results go to a summary line.
module tb_md_pad_reader;

    localparam int KIND_NONE  = 0;
    localparam int KIND_ATARI = 1;
    localparam int KIND_MD3   = 2;
    localparam int KIND_MD6   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] joy_pins;
    logic       joy_select;
    logic [5:0] db9joy_out;
    logic [5:0] md_extra_n;
    logic [1:0] pad_type;
    logic       poll_done;

    int total = 0;
    int bad   = 0;

    // Pad state: buttons active-low {mode,z,y,x,start,a,c,b,up,down,left,right}.
    int          pad_kind = KIND_NONE;
    logic [11:0] btn      = 12'hFFF;
    int          sel_cnt  = 0;
    int          high_run = 0;
    logic        prev_sel = 1'b1;

    typedef struct packed {
        logic [5:0] db9;
        logic [5:0] extra;
        logic [1:0] ptype;
    } result_t;

    typedef struct {
        int          kind;
        logic [11:0] btn;
        logic [5:0]  exp_db9;
        logic [5:0]  exp_extra;
        logic [1:0]  exp_type;
    } vec_t;

    vec_t vecs[6];

    md_pad_reader #(
        .STEP_CYCLES (4),
        .IDLE_STEPS  (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy_pins   (joy_pins),
        .joy_select (joy_select),
        .db9joy_out (db9joy_out),
        .md_extra_n (md_extra_n),
        .pad_type   (pad_type),
        .poll_done  (poll_done)
    );

    always #5 clk = ~clk;

    // Pins seen on {pin9,pin6,pin1,pin2,pin3,pin4} for a given SELECT level and
    // count of SELECT falling edges since the pad's counter last timed out.
    function automatic logic [5:0] pad_pins(int kind, logic [11:0] b, logic sel, int cnt);
        logic [5:0] p;
        p = 6'h3F;
        case (kind)
            KIND_ATARI: p = {b[5], b[4], b[3], b[2], b[1], b[0]};
            KIND_MD3:   p = sel ? {b[5], b[4], b[3], b[2], b[1], b[0]}
                                : {b[7], b[6], b[3], b[2], 2'b00};
            KIND_MD6: begin
                if (sel) p = (cnt == 3) ? {b[5], b[4], b[10], b[9], b[8], b[11]}
                                        : {b[5], b[4], b[3], b[2], b[1], b[0]};
                else     p = (cnt == 3) ? {b[7], b[6], 4'b0000}
                                        : {b[7], b[6], b[3], b[2], 2'b00};
            end
            default: p = 6'h3F;
        endcase
        return p;
    endfunction

    // The 6-button pad counts SELECT falls and forgets them after a long high.
    always @(negedge clk) begin
        if (prev_sel === 1'b1 && joy_select === 1'b0) sel_cnt = sel_cnt + 1;
        if (joy_select === 1'b1) high_run = high_run + 1;
        else high_run = 0;
        if (high_run >= 10) sel_cnt = 0;
        prev_sel = joy_select;
    end

    assign joy_pins = pad_pins(pad_kind, btn, joy_select, sel_cnt);

    // Expected poll result: pin views at the first high, first low, third low
    // and fourth high of the SELECT sequence, interpreted by the detection rules.
    function automatic result_t ref_model(int kind, logic [11:0] b);
        logic [5:0] p0, p1, p5, p6;
        logic md, six;
        result_t r;
        p0  = pad_pins(kind, b, 1'b1, 0);
        p1  = pad_pins(kind, b, 1'b0, 1);
        p5  = pad_pins(kind, b, 1'b0, 3);
        p6  = pad_pins(kind, b, 1'b1, 3);
        md  = (p1[1:0] == 2'b00);
        six = md && (p5[3:0] == 4'b0000);
        r.db9 = p0;
        if (!md) begin
            r.extra = 6'h3F;
            r.ptype = 2'd0;
        end else if (!six) begin
            r.extra = {4'hF, p1[5], p1[4]};
            r.ptype = 2'd1;
        end else begin
            r.extra = {p6[0], p6[3], p6[2], p6[1], p1[5], p1[4]};
            r.ptype = 2'd2;
        end
        return r;
    endfunction

    task automatic check_output(string name, logic [7:0] actual, logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(int kind, logic [11:0] b);
        pad_kind = kind;
        btn      = b;
    endtask

    task automatic wait_poll();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (poll_done !== 1'b1 && n < 200);
        if (poll_done !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL poll_timeout: got no poll_done expected pulse within 200 clocks");
        end
    endtask

    task automatic wait_sel_edge(logic level);
        int   n;
        logic prev;
        n    = 0;
        prev = joy_select;
        forever begin
            @(negedge clk);
            n++;
            if (joy_select === level && prev === ~level) break;
            if (n >= 200) begin
                total++;
                bad++;
                $display("[TB] FAIL select_timeout: got no SELECT edge expected one within 200 clocks");
                break;
            end
            prev = joy_select;
        end
    endtask

    task automatic check_result(string tag, result_t exp);
        check_output({tag, "_db9"},   {2'b00, db9joy_out}, {2'b00, exp.db9});
        check_output({tag, "_extra"}, {2'b00, md_extra_n}, {2'b00, exp.extra});
        check_output({tag, "_type"},  {6'b0, pad_type},    {6'b0, exp.ptype});
    endtask

    initial begin
        int      n;
        logic    torn;
        result_t exp;

        vecs[0] = '{KIND_ATARI, 12'hFEE, 6'b101110, 6'h3F,     2'd0};
        vecs[1] = '{KIND_MD3,   12'hFB7, 6'b110111, 6'b111110, 2'd1};
        vecs[2] = '{KIND_MD6,   12'h6FF, 6'h3F,     6'b011011, 2'd2};
        vecs[3] = '{KIND_NONE,  12'hFFF, 6'h3F,     6'h3F,     2'd0};
        vecs[4] = '{KIND_MD3,   12'hF5F, 6'b011111, 6'b111101, 2'd1};
        vecs[5] = '{KIND_MD6,   12'h9BD, 6'b111101, 6'b100110, 2'd2};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_select", {7'b0, joy_select}, 8'h01);
        check_output("reset_db9",    {2'b00, db9joy_out}, 8'h3F);
        check_output("reset_extra",  {2'b00, md_extra_n}, 8'h3F);
        check_output("reset_type",   {6'b0, pad_type},    8'h00);
        check_output("reset_done",   {7'b0, poll_done},   8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            wait_poll();
            apply_stimulus(vecs[i].kind, vecs[i].btn);
            wait_poll();
            check_output($sformatf("vec%0d_db9", i),   {2'b00, db9joy_out}, {2'b00, vecs[i].exp_db9});
            check_output($sformatf("vec%0d_extra", i), {2'b00, md_extra_n}, {2'b00, vecs[i].exp_extra});
            check_output($sformatf("vec%0d_type", i),  {6'b0, pad_type},    {6'b0, vecs[i].exp_type});
        end

        // Unplugged port: poll period and single-cycle commit pulse.
        apply_stimulus(KIND_NONE, 12'hFFF);
        wait_poll();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check_output("done_one_cycle", {7'b0, poll_done}, 8'h00);
        end while (poll_done !== 1'b1 && n < 200);
        check_output("poll_period", 8'(n), 8'd44);

        // B pressed during S3 must not leak into the poll already in flight.
        apply_stimulus(KIND_MD3, 12'hFFF);
        wait_poll();
        wait_sel_edge(1'b0);
        wait_sel_edge(1'b0);
        apply_stimulus(KIND_MD3, 12'hFEF);
        torn = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (db9joy_out !== 6'h3F || pad_type !== 2'd1) torn = 1'b1;
        end while (poll_done !== 1'b1 && n < 200);
        check_output("midpoll_stable", {7'b0, torn}, 8'h00);
        check_output("midpoll_db9", {2'b00, db9joy_out}, 8'h3F);
        wait_poll();
        check_output("nextpoll_db9", {2'b00, db9joy_out}, 8'b0010_1111);

        // Reset while in S4 with non-reset outputs showing.
        apply_stimulus(KIND_MD3, 12'hFB7);
        wait_poll();
        check_output("prereset_db9", {2'b00, db9joy_out}, 8'b0011_0111);
        wait_sel_edge(1'b0);
        wait_sel_edge(1'b0);
        wait_sel_edge(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("midrst_select", {7'b0, joy_select}, 8'h01);
        check_output("midrst_db9",    {2'b00, db9joy_out}, 8'h3F);
        check_output("midrst_extra",  {2'b00, md_extra_n}, 8'h3F);
        check_output("midrst_type",   {6'b0, pad_type},    8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (joy_select !== 1'b0 && n < 200);
        check_output("midrst_first_low", 8'(n), 8'd16);

        // Randomised pads against the reference model.
        for (int i = 0; i < 24; i++) begin
            int          kind;
            logic [11:0] b;
            kind = int'($urandom_range(0, 3));
            b    = 12'($urandom);
            wait_poll();
            apply_stimulus(kind, b);
            wait_poll();
            exp = ref_model(kind, b);
            check_result($sformatf("rand%0d", i), exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
